serial_bram_slave: RTL and testbench
====================================

SERIAL_BRAM_SLAVE -- requirements
Module: serial_bram_slave

Interface
REQ-001 Parameters SHALL be:
- ADDR_LEN, default 12, address width in bits.
- DATA_LEN, default 8, data beat width.
- BURST_LEN, default 12, burst-count width.
- MEM_DEPTH, default 4096, memory words.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- s_write_en, in, 1, write transaction request.
- s_read_en, in, 1, read transaction request.
- s_master_valid, in, 1, master is driving a valid serial bit this cycle.
- s_master_ready, in, 1, master accepts a read bit this cycle.
- s_rx_address, in, 1, serial address, LSB first.
- s_rx_burst, in, 1, serial burst count, LSB first.
- s_rx_data, in, 1, serial write data, LSB first.
- s_slave_delay, in, 6, extra read wait cycles.
- s_slave_ready, out, 1, slave is able to accept bits.
- s_slave_valid, out, 1, s_tx_data is valid.
- s_tx_data, out, 1, serial read data, LSB first.
- s_split_en, out, 1, slave requests a bus split.

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, WDATA, WSTORE, RWAIT, RLOAD, RDATA.
REQ-004 IDLE behaviour:
- s_slave_ready=1.
- On s_master_valid with exactly one of s_write_en/s_read_en set, SHALL latch the direction, shift in bit 0 of address and burst, and go to ADDR.
- Both enables set SHALL be ignored (stay IDLE).
REQ-005 ADDR SHALL shift one address bit and one burst bit per cycle, only on cycles where s_master_valid=1; after ADDR_LEN bits total it SHALL go to WDATA (write) or RWAIT (read). ADDR_LEN==BURST_LEN is mandatory.
REQ-006 Burst handling: burst value N SHALL mean N beats, with N=0 treated as 1 beat.
REQ-007 Address wrap: beat k SHALL use address (base+k) mod MEM_DEPTH, so 4095 wraps to 0.
REQ-008 WDATA SHALL shift s_rx_data on s_master_valid cycles; after DATA_LEN bits it SHALL go to WSTORE, write the word in one cycle with s_slave_ready=0, then return to WDATA if beats remain, else IDLE.
REQ-009 RWAIT SHALL hold for s_slave_delay cycles (value sampled on ADDR exit); 0 means it goes directly to RLOAD.
REQ-010 RLOAD SHALL take one cycle, loading the BRAM word (registered-output RAM) into the tx shift register.
REQ-011 RDATA handshake:
- s_slave_valid=1 and s_tx_data=current LSB.
- The register SHALL shift only when s_master_ready=1; s_master_ready=0 SHALL hold the bit and valid stable.
- After DATA_LEN accepted bits it SHALL go to RLOAD if beats remain, else IDLE.
REQ-012 Read latency: the first read bit SHALL be valid s_slave_delay+2 cycles after the last address bit is accepted.
REQ-013 s_slave_ready SHALL be 1 in IDLE, ADDR and WDATA, and 0 elsewhere.
REQ-014 s_tx_data SHALL be 0 whenever s_slave_valid=0.
REQ-015 The memory SHALL be a single-port MEM_DEPTH x DATA_LEN array inferable as block RAM; it SHALL NOT be reset.

Reset
REQ-016 Asserting rst=0 at any time, including mid-burst, SHALL asynchronously force:
- state IDLE;
- all shift registers and counters to 0;
- s_slave_ready=1;
- s_slave_valid=0, s_tx_data=0, s_split_en=0.
REQ-017 Memory contents SHALL be preserved across reset; a partially shifted word SHALL be discarded.

Configuration
REQ-018 With SLAVE_SPLIT_EN defined:
- s_split_en SHALL be 1 throughout RWAIT when the sampled delay is at least 4, and 0 otherwise.
- s_slave_ready SHALL be 0 during the split.
REQ-019 Without SLAVE_SPLIT_EN, s_split_en SHALL be tied to 0; RWAIT behaviour is otherwise unchanged.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state encoding;
- default ADDR_LEN/DATA_LEN/BURST_LEN;
- the split threshold constant (4).
REQ-021 The BRAM SHALL be a separate sub-module, slave_bram (synchronous write, registered read, one port); the serial shifters and FSM SHALL stay in serial_bram_slave.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single write: address 0x005, burst 1, data 0xA5, master_valid held high. Then read 0x005 with delay 0: 10100101 on s_tx_data LSB first, first bit 2 cycles after the address ends.
- Wrap burst: write burst 3 at 0xFFF with 0x11, 0x22, 0x33. Reading 0x000 SHALL return 0x22 and 0x001 SHALL return 0x33.
- Backpressure: read with s_master_ready toggling every cycle. Each bit SHALL be held until accepted; s_slave_valid SHALL stay high for 16 cycles per 8-bit beat.
- Split: read with s_slave_delay=10.
  - With SLAVE_SPLIT_EN, s_split_en SHALL be high for exactly 10 cycles.
  - Without it, s_split_en SHALL stay 0; data SHALL be identical in both builds.
- Reset mid-op: rst=0 during the 4th data bit of a write. The FSM SHALL return to IDLE immediately and the target address SHALL keep its old value; a following transaction SHALL complete normally.
- Protocol edge cases:
  - Both s_write_en and s_read_en high: no state change.
  - Burst 0: exactly one beat transferred.

Source files
------------

// File: rtl/serial_bram_slave_pkg.sv
// Shared definitions for the serial BRAM slave: FSM state encoding,
// default geometry and the read-split threshold.
package serial_bram_slave_pkg;

    localparam int DEF_ADDR_LEN  = 32'd12;
    localparam int DEF_DATA_LEN  = 32'd8;
    localparam int DEF_BURST_LEN = 32'd12;
    localparam int DEF_MEM_DEPTH = 32'd4096;

    // A read whose wait is at least this long releases the bus (split).
    localparam logic [5:0] SPLIT_THRESHOLD = 6'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WDATA  = 3'd2,
        WSTORE = 3'd3,
        RWAIT  = 3'd4,
        RLOAD  = 3'd5,
        RDATA  = 3'd6
    } state_t;

endpackage

// File: rtl/slave_bram.sv
// Single-port block RAM: synchronous write, registered read output.
// Contents are deliberately never reset so they survive a slave reset.
module slave_bram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Write port and registered read port sharing one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/serial_bram_slave.sv
// Serial bus slave fronting a block RAM. Address, burst count and write
// data arrive bit-serially (LSB first); read data leaves bit-serially with
// a valid/ready handshake. Define SLAVE_SPLIT_EN to raise s_split_en during
// long read waits; without it s_split_en is tied low.
module serial_bram_slave #(
    parameter int ADDR_LEN  = serial_bram_slave_pkg::DEF_ADDR_LEN,
    parameter int DATA_LEN  = serial_bram_slave_pkg::DEF_DATA_LEN,
    parameter int BURST_LEN = serial_bram_slave_pkg::DEF_BURST_LEN,
    parameter int MEM_DEPTH = serial_bram_slave_pkg::DEF_MEM_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_write_en,
    input  logic       s_read_en,
    input  logic       s_master_valid,
    input  logic       s_master_ready,
    input  logic       s_rx_address,
    input  logic       s_rx_burst,
    input  logic       s_rx_data,
    input  logic [5:0] s_slave_delay,
    output logic       s_slave_ready,
    output logic       s_slave_valid,
    output logic       s_tx_data,
    output logic       s_split_en
);

    import serial_bram_slave_pkg::*;

    localparam int CNT_MAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_LEN-1:0] BURST_ONE = {{(BURST_LEN-1){1'b0}}, 1'b1};
    localparam logic [ADDR_LEN-1:0]  ADDR_ONE  = {{(ADDR_LEN-1){1'b0}}, 1'b1};

    // Beat k of a burst targets (base + k) mod MEM_DEPTH.
    function automatic logic [ADDR_LEN-1:0] next_addr(input logic [ADDR_LEN-1:0] a);
        if (a == ADDR_LEN'(MEM_DEPTH - 1)) begin
            return {ADDR_LEN{1'b0}};
        end else begin
            return a + ADDR_ONE;
        end
    endfunction

    state_t                state_r;
    logic                  dir_write_r;
    // Address/burst shifters hold only the bits received so far; the newest
    // bit is concatenated combinationally, so the full word exists on the
    // cycle the last bit arrives.
    logic [ADDR_LEN-2:0]   addr_sr_r;
    logic [BURST_LEN-2:0]  burst_sr_r;
    logic [ADDR_LEN-1:0]   cur_addr_r;
    logic [BURST_LEN-1:0]  beats_left_r;
    logic [DATA_LEN-1:0]   wdata_sr_r;
    logic [DATA_LEN-1:0]   tx_sr_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [5:0]            delay_cnt_r;
    logic                  ready_r;
    logic                  valid_r;
    logic                  split_r;

    logic [ADDR_LEN-1:0]   addr_next_s;
    logic [BURST_LEN-1:0]  burst_next_s;
    logic [DATA_LEN-1:0]   wdata_next_s;
    logic [ADDR_LEN-1:0]   bram_addr_s;
    logic [DATA_LEN-1:0]   rd_data_s;
    logic                  bram_we_s;

    assign addr_next_s  = {s_rx_address, addr_sr_r};
    assign burst_next_s = {s_rx_burst, burst_sr_r};
    assign wdata_next_s = {s_rx_data, wdata_sr_r[DATA_LEN-1:1]};
    assign bram_we_s    = (state_r == WSTORE);

    // RAM address: a read word must be on the RAM output by the end of
    // RLOAD, so the address is presented one cycle ahead (the assembling
    // address in ADDR, the following beat's address in RDATA).
    always_comb begin
        bram_addr_s = cur_addr_r;
        case (state_r)
            ADDR:    bram_addr_s = addr_next_s;
            RDATA:   bram_addr_s = next_addr(cur_addr_r);
            default: bram_addr_s = cur_addr_r;
        endcase
    end

    slave_bram #(
        .ADDR_W (ADDR_LEN),
        .DATA_W (DATA_LEN),
        .DEPTH  (MEM_DEPTH)
    ) u_bram (
        .clk   (clk),
        .we    (bram_we_s),
        .addr  (bram_addr_s),
        .wdata (wdata_sr_r),
        .rdata (rd_data_s)
    );

    // Transaction FSM with shifters, counters and registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            dir_write_r  <= 1'b0;
            addr_sr_r    <= {(ADDR_LEN-1){1'b0}};
            burst_sr_r   <= {(BURST_LEN-1){1'b0}};
            cur_addr_r   <= {ADDR_LEN{1'b0}};
            beats_left_r <= {BURST_LEN{1'b0}};
            wdata_sr_r   <= {DATA_LEN{1'b0}};
            tx_sr_r      <= {DATA_LEN{1'b0}};
            bit_cnt_r    <= {CNT_W{1'b0}};
            delay_cnt_r  <= 6'd0;
            ready_r      <= 1'b1;
            valid_r      <= 1'b0;
            split_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Exactly one direction must be requested to start.
                    if (s_master_valid && (s_write_en ^ s_read_en)) begin
                        dir_write_r <= s_write_en;
                        addr_sr_r   <= addr_next_s[ADDR_LEN-1:1];
                        burst_sr_r  <= burst_next_s[BURST_LEN-1:1];
                        bit_cnt_r   <= CNT_ONE;
                        state_r     <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_master_valid) begin
                        addr_sr_r  <= addr_next_s[ADDR_LEN-1:1];
                        burst_sr_r <= burst_next_s[BURST_LEN-1:1];
                        if (bit_cnt_r == CNT_W'(ADDR_LEN - 1)) begin
                            cur_addr_r   <= addr_next_s;
                            beats_left_r <= (burst_next_s == {BURST_LEN{1'b0}}) ? BURST_ONE : burst_next_s;
                            bit_cnt_r    <= {CNT_W{1'b0}};
                            if (dir_write_r) begin
                                state_r <= WDATA;
                            end else begin
                                ready_r     <= 1'b0;
                                delay_cnt_r <= s_slave_delay;
`ifdef SLAVE_SPLIT_EN
                                split_r     <= (s_slave_delay >= SPLIT_THRESHOLD);
`else
                                split_r     <= 1'b0;
`endif
                                state_r     <= (s_slave_delay == 6'd0) ? RLOAD : RWAIT;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
                end
                WDATA: begin
                    if (s_master_valid) begin
                        wdata_sr_r <= wdata_next_s;
                        if (bit_cnt_r == CNT_W'(DATA_LEN - 1)) begin
                            bit_cnt_r <= {CNT_W{1'b0}};
                            ready_r   <= 1'b0;
                            state_r   <= WSTORE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
                end
                WSTORE: begin
                    // The RAM write happens this cycle; step to the next beat.
                    ready_r    <= 1'b1;
                    cur_addr_r <= next_addr(cur_addr_r);
                    if (beats_left_r == BURST_ONE) begin
                        state_r <= IDLE;
                    end else begin
                        beats_left_r <= beats_left_r - BURST_ONE;
                        state_r      <= WDATA;
                    end
                end
                RWAIT: begin
                    if (delay_cnt_r == 6'd1) begin
                        delay_cnt_r <= 6'd0;
                        split_r     <= 1'b0;
                        state_r     <= RLOAD;
                    end else begin
                        delay_cnt_r <= delay_cnt_r - 6'd1;
                    end
                end
                RLOAD: begin
                    tx_sr_r <= rd_data_s;
                    valid_r <= 1'b1;
                    state_r <= RDATA;
                end
                RDATA: begin
                    // Advance only on an accepted bit; otherwise hold steady.
                    if (s_master_ready) begin
                        if (bit_cnt_r == CNT_W'(DATA_LEN - 1)) begin
                            bit_cnt_r <= {CNT_W{1'b0}};
                            valid_r   <= 1'b0;
                            tx_sr_r   <= {DATA_LEN{1'b0}};
                            if (beats_left_r == BURST_ONE) begin
                                ready_r <= 1'b1;
                                state_r <= IDLE;
                            end else begin
                                beats_left_r <= beats_left_r - BURST_ONE;
                                cur_addr_r   <= next_addr(cur_addr_r);
                                state_r      <= RLOAD;
                            end
                        end else begin
                            tx_sr_r   <= {1'b0, tx_sr_r[DATA_LEN-1:1]};
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                    tx_sr_r <= {DATA_LEN{1'b0}};
                    split_r <= 1'b0;
                end
            endcase
        end
    end

    // The tx shifter is cleared whenever valid drops, so its LSB is 0 then.
    assign s_slave_ready = ready_r;
    assign s_slave_valid = valid_r;
    assign s_tx_data     = tx_sr_r[0];
    assign s_split_en    = split_r;

endmodule

// File: tb/tb_serial_bram_slave.sv
// Self-checking bench for serial_bram_slave: directed scenarios plus
// randomized write/read-back against a byte-array memory model.
module tb_serial_bram_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_write_en, s_read_en, s_master_valid, s_master_ready;
    logic       s_rx_address, s_rx_burst, s_rx_data;
    logic [5:0] s_slave_delay;
    logic       s_slave_ready, s_slave_valid, s_tx_data, s_split_en;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] ref_mem [int];
    logic [7:0] wbuf [0:7];
    logic [7:0] got  [0:7];

    always #5 clk = ~clk;

    serial_bram_slave dut (
        .clk            (clk),
        .rst            (rst),
        .s_write_en     (s_write_en),
        .s_read_en      (s_read_en),
        .s_master_valid (s_master_valid),
        .s_master_ready (s_master_ready),
        .s_rx_address   (s_rx_address),
        .s_rx_burst     (s_rx_burst),
        .s_rx_data      (s_rx_data),
        .s_slave_delay  (s_slave_delay),
        .s_slave_ready  (s_slave_ready),
        .s_slave_valid  (s_slave_valid),
        .s_tx_data      (s_tx_data),
        .s_split_en     (s_split_en)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send_header(input bit wr, input bit rd, input int addr, input int bfield, input int delay);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s_write_en     = wr;
            s_read_en      = rd;
            s_slave_delay  = delay[5:0];
            s_master_valid = 1'b1;
            s_rx_address   = addr[i];
            s_rx_burst     = bfield[i];
        end
    endtask

    // Write wbuf[0..beats-1]; abort_at >= 0 pulls reset instead of sending
    // that data bit of the first beat.
    task automatic do_write(input int addr, input int bfield, input int abort_at, input string tag);
        int beats = (bfield == 0) ? 1 : bfield;
        int g;
        send_header(1'b1, 1'b0, addr, bfield, 0);
        for (int k = 0; k < beats; k++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                s_write_en = 1'b0;
                s_read_en  = 1'b0;
                g = 0;
                while (!s_slave_ready && g < 8) begin
                    s_master_valid = 1'b0;
                    @(negedge clk);
                    g++;
                end
                chk({tag, "_wrdy"}, 32'(s_slave_ready), 32'd1);
                if (k == 0 && b == abort_at) begin
                    rst = 1'b0;
                    s_master_valid = 1'b0;
                    #1;
                    chk({tag, "_rst_ready"}, 32'(s_slave_ready), 32'd1);
                    chk({tag, "_rst_valid"}, 32'(s_slave_valid), 32'd0);
                    chk({tag, "_rst_tx"},    32'(s_tx_data),     32'd0);
                    chk({tag, "_rst_split"}, 32'(s_split_en),    32'd0);
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
                s_master_valid = 1'b1;
                s_rx_data      = wbuf[k][b];
            end
        end
        @(negedge clk);
        s_master_valid = 1'b0;
        s_rx_data      = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < beats; k++) ref_mem[(addr + k) % 4096] = wbuf[k];
    endtask

    // mode 0: always ready, 1: ready toggles starting low each beat, 2: random
    task automatic do_read(input int addr, input int bfield, input int delay, input int mode, input string tag);
        int beats = (bfield == 0) ? 1 : bfield;
        int nbits = beats * 8;
        int got_bits = 0, cyc = 0, lat = -1, vcyc = 0, split_cyc = 0, run = 0;
        int bad_tx = 0, extra = 0, split_want = 0;
        bit hold_pending = 1'b0;
        logic held_bit = 1'b0;
        logic rdy;
`ifdef SLAVE_SPLIT_EN
        if (delay >= 4) split_want = delay;
`endif
        for (int k = 0; k < 8; k++) got[k] = 8'h00;
        send_header(1'b0, 1'b1, addr, bfield, delay);
        while (got_bits < nbits && cyc < 600) begin
            @(negedge clk);
            cyc++;
            s_master_valid = 1'b0;
            s_read_en      = 1'b0;
            if (s_split_en) split_cyc++;
            if (s_slave_valid) begin
                if (lat < 0) lat = cyc;
                vcyc++;
                if (hold_pending) chk({tag, "_hold"}, 32'(s_tx_data), 32'(held_bit));
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = run[0];
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                run++;
                s_master_ready = rdy;
                if (rdy) begin
                    got[got_bits / 8][got_bits % 8] = s_tx_data;
                    got_bits++;
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = 1'b1;
                    held_bit     = s_tx_data;
                end
            end else begin
                run = 0;
                s_master_ready = 1'b0;
                if (s_tx_data !== 1'b0) bad_tx++;
            end
        end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            s_master_ready = 1'b0;
            if (s_slave_valid !== 1'b0) extra++;
        end
        chk({tag, "_bits"},   32'(got_bits),  32'(nbits));
        chk({tag, "_lat"},    32'(lat),       32'(delay + 2));
        chk({tag, "_split"},  32'(split_cyc), 32'(split_want));
        chk({tag, "_txzero"}, 32'(bad_tx),    32'd0);
        chk({tag, "_tail"},   32'(extra),     32'd0);
        chk({tag, "_idle"},   32'(s_slave_ready), 32'd1);
        if (mode == 1) chk({tag, "_vcyc"}, 32'(vcyc), 32'(16 * beats));
        for (int k = 0; k < beats; k++)
            chk({tag, "_data"}, 32'(got[k]), 32'(ref_mem[(addr + k) % 4096]));
    endtask

    initial begin
        rst = 1'b0;
        s_write_en = 1'b0; s_read_en = 1'b0; s_master_valid = 1'b0; s_master_ready = 1'b0;
        s_rx_address = 1'b0; s_rx_burst = 1'b0; s_rx_data = 1'b0; s_slave_delay = 6'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(s_slave_ready), 32'd1);
        chk("reset_valid", 32'(s_slave_valid), 32'd0);
        chk("reset_tx",    32'(s_tx_data),     32'd0);
        chk("reset_split", 32'(s_split_en),    32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single write then read with zero delay.
        wbuf[0] = 8'hA5;
        do_write(12'h005, 1, -1, "single_w");
        do_read(12'h005, 1, 0, 0, "single_r");
        chk("single_byte", 32'(got[0]), 32'h0000_00A5);

        // Burst write across the top of memory.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(12'hFFF, 3, -1, "wrap_w");
        do_read(12'h000, 1, 0, 0, "wrap_r0");
        chk("wrap_000", 32'(got[0]), 32'h0000_0022);
        do_read(12'h001, 1, 1, 0, "wrap_r1");
        chk("wrap_001", 32'(got[0]), 32'h0000_0033);

        // Backpressure with a wrapping burst read.
        do_read(12'hFFF, 3, 2, 1, "bp");
        chk("bp_b0", 32'(got[0]), 32'h0000_0011);

        // Long wait: split window.
        do_read(12'h005, 1, 10, 0, "split");
        chk("split_byte", 32'(got[0]), 32'h0000_00A5);

        // Reset during the 4th data bit keeps old memory contents.
        wbuf[0] = 8'h3C;
        do_write(12'h005, 1, 3, "rst");
        do_read(12'h005, 1, 0, 0, "post_rst");
        chk("post_rst_byte", 32'(got[0]), 32'h0000_00A5);

        // Both enables: must be ignored.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s_write_en = 1'b1; s_read_en = 1'b1; s_master_valid = 1'b1;
            s_rx_address = i[0]; s_rx_burst = 1'b0;
        end
        @(negedge clk);
        s_write_en = 1'b0; s_read_en = 1'b0; s_master_valid = 1'b0;
        do_read(12'h005, 1, 0, 0, "both_en");

        // Burst 0 means a single beat.
        wbuf[0] = 8'h77;
        do_write(12'h101, 1, -1, "b0_pre");
        wbuf[0] = 8'h5A; wbuf[1] = 8'hEE;
        do_write(12'h100, 0, -1, "b0_w");
        do_read(12'h100, 2, 0, 0, "b0_r2");
        chk("b0_first",  32'(got[0]), 32'h0000_005A);
        chk("b0_second", 32'(got[1]), 32'h0000_0077);
        do_read(12'h100, 0, 3, 2, "b0_r0");

        // Randomized write/read-back.
        for (int it = 0; it < 6; it++) begin
            int a, bf;
            a  = $urandom_range(0, 4095);
            bf = $urandom_range(0, 4);
            for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
            do_write(a, bf, -1, "rnd_w");
            do_read(a, bf, $urandom_range(0, 12), 2, "rnd_r");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
